// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation encodings and flag bit positions.
package alu_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_ADD  = 3'b000;
   localparam op_t OP_SUB  = 3'b001;
   localparam op_t OP_AND  = 3'b010;
   localparam op_t OP_OR   = 3'b011;
   localparam op_t OP_XOR  = 3'b100;
   localparam op_t OP_SHL  = 3'b101;
   localparam op_t OP_SHR  = 3'b110;
   localparam op_t OP_PASS = 3'b111;

   localparam int FLG_ZERO  = 0;
   localparam int FLG_CARRY = 1;
   localparam int FLG_NEG   = 2;
   localparam int FLG_OVF   = 3;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result bus of alu_pipe. master = operand source and result sink, slave = the ALU.
import alu_pkg::*;

interface alu_pipe_if #(parameter int WIDTH = 18);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   op_t              op;
   logic             use_acc;
   logic             acc_clear;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic [WIDTH-1:0] acc;

   modport master (
      output in_valid, a, b, op, use_acc, acc_clear, out_ready,
      input  in_ready, out_valid, result, flags, acc
   );

   modport slave (
      input  in_valid, a, b, op, use_acc, acc_clear, out_ready,
      output in_ready, out_valid, result, flags, acc
   );
endinterface

// File: rtl/alu_core.sv
// Combinational 8-op ALU datapath: (a, b, op) -> (result, {ovf, neg, carry, zero}).
import alu_pkg::*;

module alu_core #(
   parameter int WIDTH = 18,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [SHW-1:0]   sh;
   logic             sh_big;
   logic             carry;
   logic             ovf;

   assign sum    = {1'b0, a} + {1'b0, b};
   assign diff   = {1'b0, a} - {1'b0, b};
   assign sh     = b[SHW-1:0];
   // The shift field can encode counts past the word width; those flush to zero.
   assign sh_big = (32'(sh) >= WIDTH);

   always_comb begin
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
            ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result = diff[WIDTH-1:0];
            carry  = diff[WIDTH];
            ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL:  result = sh_big ? '0 : (a << sh);
         OP_SHR:  result = sh_big ? '0 : (a >> sh);
         default: result = a;
      endcase
   end

   always_comb begin
      flags            = '0;
      flags[FLG_ZERO]  = (result == '0);
      flags[FLG_CARRY] = carry;
      flags[FLG_NEG]   = result[WIDTH-1];
      flags[FLG_OVF]   = ovf;
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and an accumulator operand.
import alu_pkg::*;

module alu_pipe #(
   parameter int WIDTH = 18,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_pipe_if.slave  bus
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   op_t              s1_op_q, s1_op_d;
   logic             s1_use_acc_q, s1_use_acc_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_result_q, s2_result_d;
   logic [3:0]       s2_flags_q, s2_flags_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             s2_load;
   logic             accept;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] core_result;
   logic [3:0]       core_flags;

   // Valid/ready: a transfer happens on an edge where valid & ready are both high; valid
   // and its payload hold until transferred, and in_ready never depends on in_valid.
   assign s2_load = s1_valid_q & (~s2_valid_q | bus.out_ready);
   assign accept  = bus.in_valid & bus.in_ready;

   assign bus.in_ready  = ~s1_valid_q | s2_load;
   assign bus.out_valid = s2_valid_q;
   assign bus.result    = s2_result_q;
   assign bus.flags     = s2_flags_q;
   assign bus.acc       = acc_q;

   // acc is read and written in S2, so back-to-back accumulator ops chain without a bubble.
   assign op_b = s1_use_acc_q ? acc_q : s1_b_q;

   alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
      .a      (s1_a_q),
      .b      (op_b),
      .op     (s1_op_q),
      .result (core_result),
      .flags  (core_flags)
   );

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      s1_op_d      = s1_op_q;
      s1_use_acc_d = s1_use_acc_q;
      if (accept) begin
         s1_valid_d   = 1'b1;
         s1_a_d       = bus.a;
         s1_b_d       = bus.b;
         s1_op_d      = bus.op;
         s1_use_acc_d = bus.use_acc;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_flags_d  = s2_flags_q;
      if (s2_load) begin
         s2_valid_d  = 1'b1;
         s2_result_d = core_result;
         s2_flags_d  = core_flags;
      end else if (s2_valid_q & bus.out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_comb begin
      acc_d = acc_q;
      if (bus.acc_clear) begin
         acc_d = '0;
      end else if (s2_load & s1_use_acc_q) begin
         acc_d = core_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_op_q      <= OP_ADD;
         s1_use_acc_q <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_result_q  <= '0;
         s2_flags_q   <= '0;
         acc_q        <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_op_q      <= s1_op_d;
         s1_use_acc_q <= s1_use_acc_d;
         s2_valid_q   <= s2_valid_d;
         s2_result_q  <= s2_result_d;
         s2_flags_q   <= s2_flags_d;
         acc_q        <= acc_d;
      end
   end

endmodule
